// File: rtl/rtl_trace_buffer.sv
// -----------------------------------------------------------------------------
// rtl_trace_buffer
//   Circular pre/post-trigger trace memory fed by the signal-tap stage.
//   After arm, every valid tap sample is written into a circular buffer. The
//   first valid sample with trig_in high is the trigger; post_count further
//   samples are then stored and the buffer freezes in DONE. The host reads the
//   window back oldest-first through a registered, 1-cycle-latency port.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   sample_in    probe word from the tap
//   sample_vld   sample_in valid this cycle
//   trig_in      trigger level (only honoured together with sample_vld)
//   arm          pulse: start a new capture (restarts from any state)
//   abort        pulse: return to IDLE, keep fill_count (wins over arm)
//   post_count   samples stored after the trigger sample, sampled at arm
//   rd_en        read strobe
//   rd_addr      read index relative to the oldest stored sample
//   rd_data      read result, valid with rd_valid
//   rd_valid     1-cycle pulse, one cycle after rd_en
//   state        0 IDLE, 1 PRETRIG, 2 POSTTRIG, 3 DONE
//   done         high while in DONE
//   fill_count   samples stored since arm, saturating at DEPTH
//   trig_pos     trigger index relative to oldest, valid in DONE
// -----------------------------------------------------------------------------
module rtl_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_vld,
  input  logic              trig_in,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] post_count,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        state,
  output logic              done,
  output logic [ADDR_W:0]   fill_count,
  output logic [ADDR_W-1:0] trig_pos
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRETRIG  = 2'd1,
    S_POSTTRIG = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] REM_ONE  = ADDR_W'(1);

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (v == FULL_CNT) ? v : v + 1'b1;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_nx;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] trig_phys;

  logic              accept, wr_en, is_trig;
  logic [ADDR_W-1:0] wr_ptr_nx, oldest, oldest_nx, trig_phys_nx, rd_phys_p0;
  logic [ADDR_W:0]   fill_nx;

  // arm and abort both take precedence over a same-cycle sample write
  assign accept  = sample_vld && ((state_q == S_PRETRIG) || (state_q == S_POSTTRIG));
  assign wr_en   = accept && !abort && !arm;
  assign is_trig = wr_en && (state_q == S_PRETRIG) && trig_in;

  // Once the buffer has wrapped, the oldest sample sits at the write pointer
  assign oldest       = (fill_count == FULL_CNT) ? wr_ptr : '0;
  assign wr_ptr_nx    = wr_ptr + 1'b1;
  assign fill_nx      = sat_inc(fill_count);
  assign oldest_nx    = (fill_nx == FULL_CNT) ? wr_ptr_nx : '0;
  assign trig_phys_nx = is_trig ? wr_ptr : trig_phys;
  assign rd_phys_p0   = oldest + rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    if (abort) begin
      state_nx = S_IDLE;
    end else if (arm) begin
      state_nx = S_PRETRIG;
    end else if (wr_en) begin
      case (state_q)
        S_PRETRIG:  if (trig_in) state_nx = (remaining == '0) ? S_DONE : S_POSTTRIG;
        S_POSTTRIG: if (remaining == REM_ONE) state_nx = S_DONE;
        default:    state_nx = state_q;
      endcase
    end
  end

  always_comb begin
    state = state_q;
    done  = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      fill_count <= '0;
      remaining  <= '0;
      trig_phys  <= '0;
      trig_pos   <= '0;
    end else if (abort) begin
      // hold everything so the host can still inspect the partial capture
    end else if (arm) begin
      wr_ptr     <= '0;
      fill_count <= '0;
      remaining  <= post_count;
    end else if (wr_en) begin
      wr_ptr     <= wr_ptr_nx;
      fill_count <= fill_nx;
      trig_phys  <= trig_phys_nx;
      if (state_q == S_POSTTRIG) remaining <= remaining - 1'b1;
      // trigger position is taken against the oldest entry after this write
      if (state_nx == S_DONE) trig_pos <= trig_phys_nx - oldest_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample_in;
  end

  // ---- read stage p0 -> output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_phys_p0];
    end
  end

endmodule
